// File: rtl/binary_matrix_pkg.sv
// Shared types for the boolean matrix-vector iterator.
// Holds the FSM state encoding and the default iteration-count width.
package binary_matrix_pkg;

    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/matrix_vec_mul.sv
// One boolean-semiring step: [g;h] = [a b; c d] * [e;f].
// Ports: g,h result bits; a,b,c,d matrix bits; e,f vector bits.
module matrix_vec_mul (
    output logic g,
    output logic h,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    input  logic f
);

    assign g = (a & e) | (b & f);
    assign h = (c & e) | (d & f);

endmodule

// File: rtl/matrix_vec_iter.sv
// Applies a 2x2 boolean matrix to a 2-bit vector n times (optional early exit).
// Ports: in_* job handshake, out_* result handshake, busy when not idle.
module matrix_vec_iter
    import binary_matrix_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_m,
    input  logic [1:0]       in_v,
    input  logic [CNT_W-1:0] in_n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_v,
    output logic [CNT_W-1:0] out_iters,
    output logic             busy
);

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       m_q;
    logic [1:0]       v_q;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] iter_q;

    logic       g;
    logic       h;
    logic [1:0] step_v;
    logic       fixed_pt;
    logic       last;
    logic       accept;

    matrix_vec_mul u_mul (
        .g (g),
        .h (h),
        .a (m_q[3]),
        .b (m_q[2]),
        .c (m_q[1]),
        .d (m_q[0]),
        .e (v_q[1]),
        .f (v_q[0])
    );

    assign step_v   = {g, h};
    assign fixed_pt = (EARLY_EXIT != 0) && (step_v == v_q);
    assign last     = (rem_q == CNT_W'(1));
    assign accept   = in_valid && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = (in_n == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last || fixed_pt) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            v_q     <= '0;
            rem_q   <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                m_q    <= in_m;
                v_q    <= in_v;
                rem_q  <= in_n;
                iter_q <= '0;
            end else if (state_q == RUN) begin
                v_q    <= step_v;
                rem_q  <= rem_q - CNT_W'(1);
                iter_q <= iter_q + CNT_W'(1);
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign out_v     = out_valid ? v_q : 2'b00;
    assign out_iters = out_valid ? iter_q : '0;

endmodule

// File: tb/tb_matrix_vec_iter.sv
// Randomised self-checking bench for matrix_vec_iter (EARLY_EXIT 0 and 1).
// Both instances share stimulus; a job-level model predicts every cycle.
module tb_matrix_vec_iter;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             in_valid;
    logic             out_ready;
    logic [3:0]       in_m;
    logic [1:0]       in_v;
    logic [W-1:0]     in_n;
    logic [1:0]       in_ready;
    logic [1:0]       busy;
    logic [1:0]       out_valid;
    logic [1:0][1:0]  out_v;
    logic [1:0][W-1:0] out_iters;

    matrix_vec_iter #(.CNT_W(W), .EARLY_EXIT(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready[0]),
        .in_m      (in_m),
        .in_v      (in_v),
        .in_n      (in_n),
        .out_valid (out_valid[0]),
        .out_ready (out_ready),
        .out_v     (out_v[0]),
        .out_iters (out_iters[0]),
        .busy      (busy[0])
    );

    matrix_vec_iter #(.CNT_W(W), .EARLY_EXIT(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready[1]),
        .in_m      (in_m),
        .in_v      (in_v),
        .in_n      (in_n),
        .out_valid (out_valid[1]),
        .out_ready (out_ready),
        .out_v     (out_v[1]),
        .out_iters (out_iters[1]),
        .busy      (busy[1])
    );

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    typedef struct packed {
        logic [1:0]   v;
        logic [W-1:0] it;
    } res_t;

    // Job-level reference: iterate the boolean product directly.
    function automatic res_t ref_run(input logic [3:0] m, input logic [1:0] v,
                                     input logic [W-1:0] n, input bit ee);
        res_t r;
        logic [1:0] nv;
        r.v  = v;
        r.it = '0;
        for (int i = 0; i < int'(n); i++) begin
            nv[1] = (m[3] & r.v[1]) | (m[2] & r.v[0]);
            nv[0] = (m[1] & r.v[1]) | (m[0] & r.v[0]);
            r.it  = r.it + 1'b1;
            if (ee && nv == r.v) break;
            r.v = nv;
        end
        return r;
    endfunction

    // Model: a pending job becomes visible after res.it edges.
    logic [1:0] pend = '0;
    int         el[2] = '{0, 0};
    res_t       mres[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            for (int k = 0; k < 2; k++) el[k] <= 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (!pend[k]) begin
                    if (in_valid) begin
                        pend[k] <= 1'b1;
                        el[k]   <= 0;
                        mres[k] <= ref_run(in_m, in_v, in_n, (k == 1));
                    end
                end else if (el[k] < int'(mres[k].it)) begin
                    el[k] <= el[k] + 1;
                end else if (out_ready) begin
                    pend[k] <= 1'b0;
                end
            end
        end
    end

    function automatic int exp_word(input int k);
        logic ev;
        ev = pend[k] && (el[k] >= int'(mres[k].it));
        return int'({!pend[k], pend[k], ev,
                     ev ? mres[k].v : 2'b00,
                     ev ? mres[k].it : W'(0)});
    endfunction

    function automatic int act_word(input int k);
        return int'({in_ready[k], busy[k], out_valid[k], out_v[k], out_iters[k]});
    endfunction

    localparam int RST_WORD = 256;

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++)
                chk($sformatf("cycle dut%0d t=%0t", k, $time), act_word(k), exp_word(k));
        end
    end

    logic [1:0]   res_v[2];
    logic [W-1:0] res_i[2];
    int           lat[2];

    task automatic rand_inputs();
        in_valid = 1'($urandom_range(0, 1));
        in_m     = 4'($urandom);
        in_v     = 2'($urandom);
        in_n     = W'($urandom);
    endtask

    task automatic run_job(input logic [3:0] m, input logic [1:0] v,
                           input logic [W-1:0] n, input int hold, input bit junk);
        in_m      = m;
        in_v      = v;
        in_n      = n;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        lat = '{-1, -1};
        for (int cnt = 0; cnt <= 40; cnt++) begin
            for (int k = 0; k < 2; k++)
                if (out_valid[k] && lat[k] < 0) lat[k] = cnt;
            if (&out_valid) break;
            if (junk) rand_inputs();
            @(posedge clk);
            #2;
        end
        if (!(&out_valid)) chk("done timeout", 0, 1);
        for (int k = 0; k < 2; k++) begin
            res_v[k] = out_v[k];
            res_i[k] = out_iters[k];
        end
        for (int h = 0; h < hold; h++) begin
            if (junk) begin
                rand_inputs();
                in_valid = 1'b1;
            end
            @(posedge clk);
            #2;
            for (int k = 0; k < 2; k++)
                chk($sformatf("hold dut%0d", k),
                    int'({out_valid[k], out_v[k], out_iters[k], in_ready[k]}),
                    int'({1'b1, res_v[k], res_i[k], 1'b0}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++)
            chk($sformatf("release dut%0d", k),
                int'({in_ready[k], out_valid[k]}), 2);
    endtask

    initial begin
        #100000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        res_t r;
        logic [3:0]   rm;
        logic [1:0]   rv;
        logic [W-1:0] rn;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_m      = '0;
        in_v      = '0;
        in_n      = '0;
        #1;
        for (int k = 0; k < 2; k++)
            chk($sformatf("reset dut%0d", k), act_word(k), RST_WORD);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        r = ref_run(4'b0110, 2'b10, 4'd3, 1'b1);
        chk("model swap v", int'(r.v), 1);
        chk("model swap it", int'(r.it), 3);
        run_job(4'b0110, 2'b10, 4'd3, 0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("swap v dut%0d", k), int'(res_v[k]), 1);
            chk($sformatf("swap it dut%0d", k), int'(res_i[k]), 3);
            chk($sformatf("swap lat dut%0d", k), lat[k], 3);
        end

        r = ref_run(4'b1101, 2'b01, 4'd8, 1'b1);
        chk("model early it", int'(r.it), 2);
        run_job(4'b1101, 2'b01, 4'd8, 2, 1'b1);
        chk("early v ee1", int'(res_v[1]), 3);
        chk("early it ee1", int'(res_i[1]), 2);
        chk("early lat ee1", lat[1], 2);
        chk("early v ee0", int'(res_v[0]), 3);
        chk("early it ee0", int'(res_i[0]), 8);
        chk("early lat ee0", lat[0], 8);

        run_job(4'b1001, 2'b10, 4'd0, 1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("zero v dut%0d", k), int'(res_v[k]), 2);
            chk($sformatf("zero it dut%0d", k), int'(res_i[k]), 0);
            chk($sformatf("zero lat dut%0d", k), lat[k], 0);
        end

        run_job(4'b0110, 2'b10, 4'd2, 5, 1'b1);
        for (int k = 0; k < 2; k++)
            chk($sformatf("bp v dut%0d", k), int'(res_v[k]), 2);

        r = ref_run(4'b0110, 2'b01, 4'd15, 1'b0);
        chk("model max v", int'(r.v), 2);
        run_job(4'b0110, 2'b01, 4'd15, 0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("max v dut%0d", k), int'(res_v[k]), 2);
            chk($sformatf("max it dut%0d", k), int'(res_i[k]), 15);
            chk($sformatf("max lat dut%0d", k), lat[k], 15);
        end

        in_m     = 4'b0110;
        in_v     = 2'b10;
        in_n     = 4'd15;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++)
            chk($sformatf("midrun reset dut%0d", k), act_word(k), RST_WORD);
        @(posedge clk);
        #2;
        for (int k = 0; k < 2; k++)
            chk($sformatf("reset held dut%0d", k), act_word(k), RST_WORD);
        rst_n = 1'b1;
        run_job(4'b0110, 2'b10, 4'd5, 0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("post-reset v dut%0d", k), int'(res_v[k]), 1);
            chk($sformatf("post-reset it dut%0d", k), int'(res_i[k]), 5);
        end

        for (int j = 0; j < 30; j++) begin
            rm = 4'($urandom);
            rv = 2'($urandom);
            rn = W'($urandom);
            run_job(rm, rv, rn, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            for (int k = 0; k < 2; k++) begin
                r = ref_run(rm, rv, rn, (k == 1));
                chk($sformatf("rand%0d dut%0d", j, k),
                    int'({res_v[k], res_i[k]}), int'({r.v, r.it}));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
